// File: rtl/serial_add_pkg.sv
`timescale 1ns/1ps
// Shared types and defaults for the bit-serial add/subtract controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_e;

    localparam int SERIAL_ADD_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_if.sv
`timescale 1ns/1ps
// Operand/result handshake bundle for serial_add_ctrl.
// Optional macro SERIAL_ADD_SUB_EN adds the 1-bit 'sub' request.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             negative;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout, overflow, negative, zero, busy
    );

    modport slave (
        input  in_valid, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout, overflow, negative, zero, busy
    );

endinterface

// File: rtl/full_adder.sv
`timescale 1ns/1ps
// Single-bit full adder; time-shared across all bit positions by serial_add_ctrl.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
`timescale 1ns/1ps
// Bit-serial add/subtract sequencer: one full_adder, one bit per clock, N/Z/C/V flags.
// Optional macro SERIAL_ADD_SUB_EN enables subtraction via the interface 'sub' bit.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_DEFAULT_WIDTH
) (
    input logic              clk,
    input logic              reset_n,
    serial_add_ctrl_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    ctrl_state_e      state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    count;

    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             overflow_q;
    logic             negative_q;
    logic             zero_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Sum register keeps only the WIDTH-1 bits collected so far; the live adder bit completes it.
    assign sum_next = {fa_sum, sum_sh};

    always_comb begin
        b_load     = bus.b;
        carry_load = bus.cin;
`ifdef SERIAL_ADD_SUB_EN
        if (bus.sub) begin
            b_load     = ~bus.b;
            carry_load = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            sum_sh      <= '0;
            carry       <= 1'b0;
            count       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            negative_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_sh       <= bus.a;
                        b_sh       <= b_load;
                        carry      <= carry_load;
                        count      <= '0;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    sum_sh <= sum_next[WIDTH-1:1];
                    carry  <= fa_cout;
                    if (count == CW'(WIDTH - 1)) begin
                        // carry still holds the carry into the MSB on this last step
                        sum_q       <= sum_next;
                        cout_q      <= fa_cout;
                        overflow_q  <= carry ^ fa_cout;
                        negative_q  <= fa_sum;
                        zero_q      <= (sum_next == '0);
                        state       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = overflow_q;
    assign bus.negative  = negative_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
`timescale 1ns/1ps
// Directed self-checking bench for serial_add_ctrl (WIDTH=8).
// Subtraction scenario is compiled in when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        @(negedge clk);
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = cv;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (bus.out_valid !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            failures++;
            $display("FAIL reset_ctrl in_ready/out_valid/busy=%b required 100",
                     {bus.in_ready, bus.out_valid, bus.busy});
        end
        checks++;
        if ({bus.sum, bus.cout, bus.overflow, bus.negative, bus.zero} !== 12'h000) begin
            failures++;
            $display("FAIL reset_result sum=%h cvnz=%b required sum=00 cvnz=0000",
                     bus.sum, {bus.cout, bus.overflow, bus.negative, bus.zero});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_add_overflow();
        int cyc;
        start_op(8'h7F, 8'h01, 1'b0);
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL run_flags busy=%b in_ready=%b required busy=1 in_ready=0",
                     bus.busy, bus.in_ready);
        end
        wait_valid(cyc);
        checks++;
        if (cyc != 8) begin
            failures++;
            $display("FAIL ovf_latency got %0d cycles required 8", cyc);
        end
        checks++;
        if ({bus.sum, bus.cout, bus.overflow, bus.negative, bus.zero} !== {8'h80, 4'b0110}) begin
            failures++;
            $display("FAIL ovf_result sum=%h cvnz=%b required sum=80 cvnz=0110",
                     bus.sum, {bus.cout, bus.overflow, bus.negative, bus.zero});
        end
        consume();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ovf_release out_valid=%b in_ready=%b required 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_add_carry_zero();
        int cyc;
        start_op(8'hFF, 8'h01, 1'b0);
        wait_valid(cyc);
        checks++;
        if (cyc != 8) begin
            failures++;
            $display("FAIL carry_latency got %0d cycles required 8", cyc);
        end
        checks++;
        if ({bus.sum, bus.cout, bus.overflow, bus.negative, bus.zero} !== {8'h00, 4'b1001}) begin
            failures++;
            $display("FAIL carry_result sum=%h cvnz=%b required sum=00 cvnz=1001",
                     bus.sum, {bus.cout, bus.overflow, bus.negative, bus.zero});
        end
        consume();
    endtask

    task automatic test_backpressure();
        int cyc;
        start_op(8'h10, 8'h20, 1'b1);
        wait_valid(cyc);
        checks++;
        if (cyc != 8) begin
            failures++;
            $display("FAIL bp_latency got %0d cycles required 8", cyc);
        end
        // offer new operands while the result is stalled; they must not be taken
        bus.a        = 8'hAA;
        bus.b        = 8'h11;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.sum !== 8'h31 || bus.in_ready !== 1'b0 ||
                {bus.cout, bus.overflow, bus.negative, bus.zero} !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold[%0d] out_valid=%b sum=%h in_ready=%b cvnz=%b required 1/31/0/0000",
                         i, bus.out_valid, bus.sum, bus.in_ready,
                         {bus.cout, bus.overflow, bus.negative, bus.zero});
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        consume();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
            bus.sum !== 8'h31) begin
            failures++;
            $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b sum=%h required 0/1/0/31",
                     bus.out_valid, bus.in_ready, bus.busy, bus.sum);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen = 0;
        start_op(8'h12, 8'h34, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100 ||
            {bus.sum, bus.cout, bus.overflow, bus.negative, bus.zero} !== 12'h000) begin
            failures++;
            $display("FAIL midrun_reset in_ready/out_valid/busy=%b sum=%h cvnz=%b required 100/00/0000",
                     {bus.in_ready, bus.out_valid, bus.busy}, bus.sum,
                     {bus.cout, bus.overflow, bus.negative, bus.zero});
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midrun_after out_valid_pulses=%0d in_ready=%b busy=%b required 0/1/0",
                     seen, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] av [3] = '{8'h01, 8'h80, 8'h55};
        logic [W-1:0] bv [3] = '{8'h02, 8'h80, 8'hAA};
        logic         cv [3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] es [3] = '{8'h03, 8'h00, 8'h00};
        logic [3:0]   ef [3] = '{4'b0000, 4'b1101, 4'b1001};
        int idx = 0, nres = 0, t = 0, last_t = 0, accepts = 0;
        bit pending = 1'b0;
        @(negedge clk);
        bus.a         = av[0];
        bus.b         = bv[0];
        bus.cin       = cv[0];
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while (nres < 3 && t < 60) begin
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (bus.sum !== es[nres] ||
                    {bus.cout, bus.overflow, bus.negative, bus.zero} !== ef[nres]) begin
                    failures++;
                    $display("FAIL b2b_result[%0d] sum=%h cvnz=%b required sum=%h cvnz=%b",
                             nres, bus.sum, {bus.cout, bus.overflow, bus.negative, bus.zero},
                             es[nres], ef[nres]);
                end
                if (nres > 0) begin
                    checks++;
                    if (t - last_t != 10) begin
                        failures++;
                        $display("FAIL b2b_spacing[%0d] got %0d cycles required 10", nres, t - last_t);
                    end
                end
                last_t = t;
                nres++;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                pending = 1'b1;
                accepts++;
            end
            @(negedge clk);
            t++;
            if (pending) begin
                pending = 1'b0;
                idx++;
                if (idx < 3) begin
                    bus.a   = av[idx];
                    bus.b   = bv[idx];
                    bus.cin = cv[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (nres != 3 || accepts != 3) begin
            failures++;
            $display("FAIL b2b_count results=%0d accepts=%0d required 3/3", nres, accepts);
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int cyc;
        bus.sub = 1'b1;
        start_op(8'h05, 8'h07, 1'b0);
        bus.sub = 1'b0;
        wait_valid(cyc);
        checks++;
        if (cyc != 8 || bus.sum !== 8'hFE ||
            {bus.cout, bus.overflow, bus.negative, bus.zero} !== 4'b0010) begin
            failures++;
            $display("FAIL sub_result cycles=%0d sum=%h cvnz=%b required 8/FE/0010",
                     cyc, bus.sum, {bus.cout, bus.overflow, bus.negative, bus.zero});
        end
        consume();
    endtask
`endif

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub       = 1'b0;
`endif
        test_reset();
        test_add_overflow();
        test_add_carry_zero();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract controller. It sequences a single full_adder instance over WIDTH bits, one bit per clock, with a registered carry between bits.
- Accepts an operand pair over a valid/ready handshake and returns sum plus N/Z/C/V flags over a second valid/ready handshake.
- Serves as the low-area arithmetic path for the datapath. It is the sequencer that owns and time-shares the one full_adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to clk.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of bit WIDTH-1 (ARM C).
- overflow  output  1  signed overflow (ARM V).
- negative  output  1  sum[WIDTH-1] (ARM N).
- zero  output  1  sum == 0 (ARM Z).
- busy  output  1  high in RUN state.

Behaviour:
- Reset values:
  - state = IDLE; in_ready = 1.
  - out_valid, busy, sum, cout, overflow, negative, zero = 0.
  - Internal a/b shift registers, sum shift register, carry register and bit counter = 0.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: load a_sh = a, b_sh = b, carry = cin, count = 0; go to RUN.
- RUN:
  - in_ready = 0 and busy = 1. in_valid is ignored and the operands are not sampled.
  - Each cycle the full_adder sees a_sh[0], b_sh[0] and carry.
  - At the edge:
    - the Sum bit shifts into the MSB of the sum shift register (shift right);
    - a_sh and b_sh shift right;
    - carry <= Cout;
    - count increments.
  - At count == WIDTH-1 the edge also does the following, then goes to DONE:
    - registers sum from the final shift value;
    - cout = final Cout;
    - overflow = (carry into MSB) XOR (carry out of MSB);
    - negative = final sum MSB;
    - zero = (final sum == 0).
- DONE:
  - out_valid = 1. All result outputs are held stable until out_ready.
  - On out_valid && out_ready: go to IDLE with out_valid = 0 at the next edge. The result outputs keep their last value until the next DONE.
- Latency and throughput:
  - The accept edge is E0. out_valid rises after edge E0+WIDTH.
  - With out_ready tied high, throughput is one operation per WIDTH+2 cycles.
  - No in/out bypass: in_ready stays 0 in DONE even when out_ready = 1.
- Timing: the full_adder carries 100 ps worst-case gate delay per bit, so benches use a clock period ≥ 1000 ps.
- Reset mid-operation: an asynchronous return to the reset values. The partial result is discarded and no out_valid pulse is produced.
- Counter width is $clog2(WIDTH). The counter never wraps in operation because the state leaves RUN at WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - adds input port sub (1 bit), sampled with the operands at accept;
  - when sub = 1, b_sh loads ~b and carry loads 1, and cin is ignored;
  - cout then follows ARM convention: 1 = no borrow.
- Undefined: no sub port; add only.

Decomposition:
- Shared package serial_add_pkg:
  - state enum ctrl_state_e {IDLE, RUN, DONE} (2 bits);
  - localparam SERIAL_ADD_DEFAULT_WIDTH = 8.
- Sub-module: the existing full_adder, instantiated exactly once. The shift/count/state logic stays in serial_add_ctrl; no further split.

Test Plan:
- WIDTH=8, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1, negative=1, zero=0; out_valid 8 cycles after accept.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, zero=1, overflow=0, negative=0.
- a=0x10, b=0x20, cin=1, with out_ready held low 5 cycles -> out_valid stays 1, sum=0x31 stable, in_ready=0 throughout; IDLE one cycle after out_ready=1.
- reset_n pulsed low on the 3rd RUN cycle -> outputs zero immediately, in_ready=1 after release, no out_valid pulse.
- in_valid and out_ready held high with 3 queued operand pairs -> exactly 3 results, one every 10 cycles; in_valid during RUN never accepted.
- With SERIAL_ADD_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, negative=1, overflow=0.
